// File: rtl/dtmf_pkg.sv
// Shared definitions for the DTMF dial sequencer.
//   state_e    : playback FSM encoding (IDLE/LOAD/TONE/GAP)
//   IDX_W      : width of a row or column tone index
//   key_rc_t   : row/column index pair for one key
//   key_to_rc  : maps a 4-bit key code onto its row/column tone pair
package dtmf_pkg;

  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_TONE = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
  } key_rc_t;

  // Keypad layout: rows 697/770/852/941 Hz, columns 1209/1336/1477/1633 Hz.
  // E is the '*' key and F is the '#' key on the bottom row.
  function automatic key_rc_t key_to_rc(input logic [3:0] key);
    key_rc_t rc;
    case (key)
      4'h0:    rc = '{row: 2'd3, col: 2'd1};
      4'h1:    rc = '{row: 2'd0, col: 2'd0};
      4'h2:    rc = '{row: 2'd0, col: 2'd1};
      4'h3:    rc = '{row: 2'd0, col: 2'd2};
      4'h4:    rc = '{row: 2'd1, col: 2'd0};
      4'h5:    rc = '{row: 2'd1, col: 2'd1};
      4'h6:    rc = '{row: 2'd1, col: 2'd2};
      4'h7:    rc = '{row: 2'd2, col: 2'd0};
      4'h8:    rc = '{row: 2'd2, col: 2'd1};
      4'h9:    rc = '{row: 2'd2, col: 2'd2};
      4'hA:    rc = '{row: 2'd0, col: 2'd3};
      4'hB:    rc = '{row: 2'd1, col: 2'd3};
      4'hC:    rc = '{row: 2'd2, col: 2'd3};
      4'hD:    rc = '{row: 2'd3, col: 2'd3};
      4'hE:    rc = '{row: 2'd3, col: 2'd0};
      default: rc = '{row: 2'd3, col: 2'd2};
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/dtmf_digit_fifo.sv
// Synchronous digit queue for the DTMF dial sequencer.
//   clk, reset_n : clock, asynchronous active-low reset
//   push/wr_data : write one 4-bit key code (ignored when full or flushing)
//   pop/rd_data  : rd_data is the head entry; pop removes it (ignored when empty or flushing)
//   flush        : empties the queue; wins over push and pop in the same cycle
//   full/empty   : occupancy flags
//   count        : entries held, 0..DEPTH
module dtmf_digit_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [3:0]             wr_data,
  input  logic                   pop,
  output logic [3:0]             rd_data,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_en;
  logic          pop_en;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/dtmf_dial_sequencer.sv
// Queued DTMF dialler. Key codes arrive on a valid/ready port, wait in a FIFO,
// and are played one at a time as a TONE_CYCLES tone burst followed by
// GAP_CYCLES of silence.
//   clk, reset_n           : clock, asynchronous active-low reset
//   row_tone, col_tone     : free-running square-wave tones, one bit per row/column
//   digit_in/valid/ready   : key input; a transfer happens when valid && ready
//   en                     : playback enable; dropping it aborts the current digit
//   flush                  : synchronous; empties the queue and aborts playback
//   out_row, out_column    : registered selected tones, 0 when silent
//   busy                   : FSM in LOAD/TONE/GAP
//   cur_digit              : last digit taken from the queue
//   fifo_count             : queued entries
//   dbg_state              : raw FSM state (dtmf_pkg::state_e encoding)
//
// Handshake: digit_ready depends only on queue fullness and flush, never on
// digit_valid; a key is taken on every rising edge where valid && ready.
module dtmf_dial_sequencer
  import dtmf_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int TONE_CYCLES = 1200000,
  parameter int GAP_CYCLES  = 1200000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [3:0]                  row_tone,
  input  logic [3:0]                  col_tone,
  input  logic [3:0]                  digit_in,
  input  logic                        digit_valid,
  output logic                        digit_ready,
  input  logic                        en,
  input  logic                        flush,
  output logic                        out_row,
  output logic                        out_column,
  output logic                        busy,
  output logic [3:0]                  cur_digit,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [1:0]                  dbg_state
);

  localparam int MAX_CYC = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cur_digit_q, cur_digit_d;
  logic [IDX_W-1:0] row_idx_q, row_idx_d;
  logic [IDX_W-1:0] col_idx_q, col_idx_d;
  logic             out_row_q, out_row_d;
  logic             out_col_q, out_col_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic [3:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  key_rc_t          head_rc;

  assign digit_ready = !fifo_full && !flush;
  assign fifo_push   = digit_valid && digit_ready;
  assign head_rc     = key_to_rc(fifo_head);

  dtmf_digit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wr_data (digit_in),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .flush   (flush),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cur_digit_q <= '0;
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      out_row_q   <= 1'b0;
      out_col_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_digit_q <= cur_digit_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  // Next-state logic. The pop happens on the IDLE->LOAD transition, so the
  // head digit and its tone indices are latched on that same edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_digit_d = cur_digit_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    fifo_pop    = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q != ST_IDLE && !en) begin
      // Abort: the popped digit is dropped, the rest of the queue stays.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en && !fifo_empty) begin
            fifo_pop    = 1'b1;
            state_d     = ST_LOAD;
            cur_digit_d = fifo_head;
            row_idx_d   = head_rc.row;
            col_idx_d   = head_rc.col;
          end
        end
        ST_LOAD: begin
          cnt_d   = TONE_LOAD;
          state_d = ST_TONE;
        end
        ST_TONE: begin
          if (cnt_q == '0) begin
            cnt_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic. Tones are re-registered so they lag the state by one clock;
  // gating with en/flush silences them on the very next edge after an abort.
  always_comb begin
    out_row_d = 1'b0;
    out_col_d = 1'b0;
    if (state_q == ST_TONE && en && !flush) begin
      out_row_d = row_tone[row_idx_q];
      out_col_d = col_tone[col_idx_q];
    end
  end

  assign out_row    = out_row_q;
  assign out_column = out_col_q;
  assign busy       = (state_q != ST_IDLE);
  assign cur_digit  = cur_digit_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dtmf_dial_sequencer.sv
// Directed bench for dtmf_dial_sequencer with short tone/gap timing.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_dtmf_dial_sequencer;
  import dtmf_pkg::*;

  localparam int DEPTH = 4;
  localparam int TONE  = 8;
  localparam int GAP   = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] row_tone;
  logic [3:0] col_tone;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;
  logic       en;
  logic       flush;
  logic       out_row;
  logic       out_column;
  logic       busy;
  logic [3:0] cur_digit;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  // Scoreboard of digits expected to play, in order.
  logic [3:0] exp_q[$];

  // Hand-written keypad table (row, column) per key code.
  logic [1:0] key_row [16] = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                               2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [1:0] key_col [16] = '{2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0,
                               2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd2};

  dtmf_dial_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .TONE_CYCLES (TONE),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .row_tone    (row_tone),
    .col_tone    (col_tone),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .en          (en),
    .flush       (flush),
    .out_row     (out_row),
    .out_column  (out_column),
    .busy        (busy),
    .cur_digit   (cur_digit),
    .fifo_count  (fifo_count),
    .dbg_state   (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one key for one edge; caller guarantees ready is high.
  task automatic push(input logic [3:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    exp_q.push_back(d);
  endtask

  // Entered in IDLE with en=1 and the next scoreboard digit at the queue head.
  // Follows it through LOAD, TONE and GAP and returns with the FSM back in IDLE.
  // With walk=1 the tone inputs are stepped through one-hot patterns during the
  // first half of the burst so every row/column index is distinguishable.
  task automatic expect_digit(input bit walk);
    logic [3:0] d;
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] rt;
    logic [3:0] ct;
    d = exp_q.pop_front();
    r = key_row[d];
    c = key_col[d];
    tick();
    check("load_busy", busy, 1);
    check("load_digit", cur_digit, d);
    check("load_count", fifo_count, exp_q.size());
    check("load_ready", digit_ready, 1);
    tick();
    check("tone_lag_row", out_row, 0);
    check("tone_lag_col", out_column, 0);
    for (int i = 0; i < TONE; i++) begin
      rt = (walk && i < 4) ? (4'b0001 << i) : 4'b0101;
      ct = (walk && i < 4) ? (4'b1000 >> i) : 4'b1010;
      row_tone = rt;
      col_tone = ct;
      tick();
      check("tone_row", out_row, rt[r]);
      check("tone_col", out_column, ct[c]);
    end
    row_tone = 4'b0101;
    col_tone = 4'b1010;
    for (int i = 0; i < GAP; i++) begin
      tick();
      check("gap_row", out_row, 0);
      check("gap_col", out_column, 0);
      check("gap_busy", busy, (i < GAP - 1) ? 1 : 0);
    end
  endtask

  initial begin
    row_tone    = 4'b0101;
    col_tone    = 4'b1010;
    digit_in    = 4'h0;
    digit_valid = 1'b0;
    en          = 1'b0;
    flush       = 1'b0;

    // Reset state
    tick(2);
    check("rst_ready", digit_ready, 1);
    check("rst_row", out_row, 0);
    check("rst_col", out_column, 0);
    check("rst_busy", busy, 0);
    check("rst_digit", cur_digit, 0);
    check("rst_count", fifo_count, 0);
    reset_n = 1'b1;
    tick();

    // Single digit 5: tones on N+3..N+10, silent gap, busy falls after the gap.
    en = 1'b1;
    push(4'h5);
    check("t1_count_after_push", fifo_count, 1);
    check("t1_idle_after_push", busy, 0);
    expect_digit(1'b0);

    // Four back-to-back pushes fill the queue, then play in order.
    en = 1'b0;
    push(4'h1);
    push(4'h2);
    push(4'h3);
    push(4'h4);
    check("t2_full_ready", digit_ready, 0);
    check("t2_full_count", fifo_count, 4);
    en = 1'b1;
    while (exp_q.size() != 0) expect_digit(1'b0);

    // Sweep of every key code through the keypad map.
    for (int k = 0; k < 16; k++) begin
      push(4'(k));
      expect_digit(1'b1);
    end

    // Drop en mid-TONE of 7; queued 8 plays in full afterwards.
    en = 1'b0;
    push(4'h7);
    push(4'h8);
    en = 1'b1;
    void'(exp_q.pop_front());
    tick();
    check("t4_load_digit", cur_digit, 4'h7);
    tick(2);
    check("t4_tone_on", out_row, 1);
    en = 1'b0;
    tick();
    check("t4_abort_row", out_row, 0);
    check("t4_abort_col", out_column, 0);
    check("t4_abort_busy", busy, 0);
    tick(2);
    check("t4_hold_busy", busy, 0);
    check("t4_hold_count", fifo_count, 1);
    en = 1'b1;
    expect_digit(1'b0);

    // Flush with three queued while a push is offered.
    en = 1'b0;
    push(4'h1);
    push(4'h2);
    push(4'h3);
    check("t5_count_before", fifo_count, 3);
    digit_in    = 4'($urandom_range(0, 15));
    digit_valid = 1'b1;
    flush       = 1'b1;
    #1;
    check("t5_ready_in_flush", digit_ready, 0);
    tick();
    flush       = 1'b0;
    digit_valid = 1'b0;
    exp_q.delete();
    #1;
    check("t5_count", fifo_count, 0);
    check("t5_busy", busy, 0);
    check("t5_state", dbg_state, ST_IDLE);
    check("t5_ready", digit_ready, 1);
    check("t5_digit_held", cur_digit, 4'h8);
    en = 1'b1;
    tick(3);
    check("t5_no_play", busy, 0);
    check("t5_still_empty", fifo_count, 0);

    // Reset mid-GAP with one digit still queued.
    push(4'h6);
    digit_in    = 4'h3;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    check("t6_pushpop_count", fifo_count, 1);
    check("t6_digit", cur_digit, 4'h6);
    tick(10);
    check("t6_in_gap_busy", busy, 1);
    check("t6_in_gap_state", dbg_state, ST_GAP);
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_row", out_row, 0);
    check("t6_rst_col", out_column, 0);
    check("t6_rst_digit", cur_digit, 0);
    check("t6_rst_ready", digit_ready, 1);
    exp_q.delete();
    tick(2);
    reset_n = 1'b1;
    tick();
    check("t6_post_busy", busy, 0);
    check("t6_post_count", fifo_count, 0);
    push(4'hD);
    expect_digit(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
